// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read addresses/data/busy for NREAD ports,
// plus one write port and one reserve port.
//
// Handshake: none. There is no valid/ready pair on this bus. The slave
// accepts one write (RegWr) and one reserve (RsvWr) on every rising clock
// edge. Read outputs are combinational and valid in the same cycle as RA.
interface regfile_mp_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32,
   parameter int NREAD = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NREAD*AW-1:0]    RA;
   logic [NREAD*WIDTH-1:0] BusA;
   logic [NREAD-1:0]       BusyA;
   logic [AW-1:0]          RW;
   logic [WIDTH-1:0]       BusW;
   logic                   RegWr;
   logic                   RsvWr;
   logic [AW-1:0]          RsvReg;

   modport master (
      output RA, RW, BusW, RegWr, RsvWr, RsvReg,
      input  BusA, BusyA
   );

   modport slave (
      input  RA, RW, BusW, RegWr, RsvWr, RsvReg,
      output BusA, BusyA
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register busy scoreboard.
// It has an optional hardwired-zero register and optional same-cycle
// write forwarding. Busy bits are set by reserves (load issued) and
// cleared by writes. The hazard unit reads them on BusyA.
module regfile_mp #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter bit ZERO_EN  = 1'b1,
   parameter int ZERO_IDX = DEPTH - 1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic         Clk,
   input  logic         Reset,
   regfile_mp_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [DEPTH-1:0]       busy;
   logic                   wr_ok;
   logic                   rsv_ok;
   logic [NREAD*WIDTH-1:0] rd_data;
   logic [NREAD-1:0]       rd_busy;

   // When the zero register is enabled, writes and reserves aimed at it are
   // dropped. Its storage and busy bit therefore never leave 0.
   assign wr_ok  = bus.RegWr && !(ZERO_EN && (bus.RW == ZERO_A));
   assign rsv_ok = bus.RsvWr && !(ZERO_EN && (bus.RsvReg == ZERO_A));

   // Storage and scoreboard update. Reset overrides everything. The reserve
   // is applied after the write, so a same-register write+reserve leaves the
   // register busy (a new load to that destination has been issued).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            mem[bus.RW]  <= bus.BusW;
            busy[bus.RW] <= 1'b0;
         end
         if (rsv_ok) begin
            busy[bus.RsvReg] <= 1'b1;
         end
      end
   end

   // Independent combinational read ports. Priority is: hardwired zero,
   // then same-cycle write forward, then the stored value and busy bit.
   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit_zero;
      logic          hit_byp;

      assign addr     = bus.RA[p*AW +: AW];
      assign hit_zero = ZERO_EN && (addr == ZERO_A);
      assign hit_byp  = BYPASS && bus.RegWr && (bus.RW == addr);

      assign rd_data[p*WIDTH +: WIDTH] = hit_zero ? '0 :
                                         hit_byp  ? bus.BusW :
                                                    mem[addr];
      assign rd_busy[p] = !hit_zero && !hit_byp && busy[addr];
   end

   assign bus.BusA  = rd_data;
   assign bus.BusyA = rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. It uses three instances:
//   u_a: default parameters (BYPASS=1, zero register r31),
//   u_b: the same but BYPASS=0 (driven identically to u_a),
//   u_c: WIDTH=32, DEPTH=16, NREAD=3, ZERO_EN=0.
// The bench runs a directed vector table, a few hand sequences and then
// random cycles, all checked against an array-based reference model.
module tb_regfile_mp;
   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NREAD(2)) if_a ();
   regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NREAD(2)) if_b ();
   regfile_mp_if #(.WIDTH(32), .DEPTH(16), .NREAD(3)) if_c ();

   regfile_mp #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_EN(1'b1), .ZERO_IDX(31), .BYPASS(1'b1))
      u_a (.Clk(Clk), .Reset(Reset), .bus(if_a));
   regfile_mp #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_EN(1'b1), .ZERO_IDX(31), .BYPASS(1'b0))
      u_b (.Clk(Clk), .Reset(Reset), .bus(if_b));
   regfile_mp #(.WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_EN(1'b0), .ZERO_IDX(15), .BYPASS(1'b1))
      u_c (.Clk(Clk), .Reset(Reset), .bus(if_c));

   // Reference model: plain arrays holding register contents and busy flags.
   logic [63:0] m_reg  [32];
   logic        m_busy [32];
   logic [31:0] c_reg  [16];
   logic        c_busy [16];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive the write, reserve and read inputs of u_a and u_b identically.
   task automatic set_ab(input logic wr, input logic [4:0] rw, input logic [63:0] w,
                         input logic rsv, input logic [4:0] rr,
                         input logic [4:0] a0, input logic [4:0] a1);
      if_a.RegWr = wr;  if_a.RW = rw;  if_a.BusW = w;
      if_a.RsvWr = rsv; if_a.RsvReg = rr; if_a.RA = {a1, a0};
      if_b.RegWr = wr;  if_b.RW = rw;  if_b.BusW = w;
      if_b.RsvWr = rsv; if_b.RsvReg = rr; if_b.RA = {a1, a0};
   endtask

   task automatic set_c(input logic wr, input logic [3:0] rw, input logic [31:0] w,
                        input logic rsv, input logic [3:0] rr, input logic [11:0] ra);
      if_c.RegWr = wr;  if_c.RW = rw;  if_c.BusW = w;
      if_c.RsvWr = rsv; if_c.RsvReg = rr; if_c.RA = ra;
   endtask

   // Expected read {busy, data} for the 32x64 instances. The answer depends
   // on whether the instance forwards the current write.
   function automatic logic [64:0] exp_ab(input logic [4:0] a, input bit byp);
      if (a == 5'd31) return '0;
      if (byp && if_a.RegWr && (if_a.RW == a)) return {1'b0, if_a.BusW};
      return {m_busy[a], m_reg[a]};
   endfunction

   function automatic logic [32:0] exp_c(input logic [3:0] a);
      if (if_c.RegWr && (if_c.RW == a)) return {1'b0, if_c.BusW};
      return {c_busy[a], c_reg[a]};
   endfunction

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      @(posedge Clk);
      if (Reset) begin
         for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
         for (int i = 0; i < 16; i++) begin c_reg[i] = '0; c_busy[i] = 1'b0; end
      end else begin
         if (if_a.RegWr && if_a.RW != 5'd31) begin
            m_reg[if_a.RW]  = if_a.BusW;
            m_busy[if_a.RW] = 1'b0;
         end
         if (if_a.RsvWr && if_a.RsvReg != 5'd31) m_busy[if_a.RsvReg] = 1'b1;
         if (if_c.RegWr) begin
            c_reg[if_c.RW]  = if_c.BusW;
            c_busy[if_c.RW] = 1'b0;
         end
         if (if_c.RsvWr) c_busy[if_c.RsvReg] = 1'b1;
      end
      #1;
   endtask

   task automatic check_ab_model(input bit do_a);
      logic [4:0]  a;
      logic [64:0] e;
      for (int p = 0; p < 2; p++) begin
         a = if_b.RA[p*5 +: 5];
         e = exp_ab(a, 1'b0);
         check($sformatf("b_data%0d r%0d", p, a), if_b.BusA[p*64 +: 64], e[63:0]);
         check($sformatf("b_busy%0d r%0d", p, a), {63'd0, if_b.BusyA[p]}, {63'd0, e[64]});
         if (do_a) begin
            e = exp_ab(a, 1'b1);
            check($sformatf("a_data%0d r%0d", p, a), if_a.BusA[p*64 +: 64], e[63:0]);
            check($sformatf("a_busy%0d r%0d", p, a), {63'd0, if_a.BusyA[p]}, {63'd0, e[64]});
         end
      end
   endtask

   task automatic check_c_model();
      logic [3:0]  a;
      logic [32:0] e;
      for (int p = 0; p < 3; p++) begin
         a = if_c.RA[p*4 +: 4];
         e = exp_c(a);
         check($sformatf("c_data%0d r%0d", p, a), {32'd0, if_c.BusA[p*32 +: 32]}, {32'd0, e[31:0]});
         check($sformatf("c_busy%0d r%0d", p, a), {63'd0, if_c.BusyA[p]}, {63'd0, e[32]});
      end
   endtask

   function automatic logic [4:0] pick_a();
      if ($urandom_range(0, 3) == 0) return 5'd31;
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   typedef struct {
      logic        rst;
      logic        wr;
      logic [4:0]  rw;
      logic [63:0] w;
      logic        rsv;
      logic [4:0]  rr;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic        chk;
      logic [63:0] d0;
      logic        b0;
      logic [63:0] d1;
      logic        b1;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

   initial begin
      // Directed vectors for u_a, with expected values for the cycle before
      // each edge.
      //          rst  wr  rw     w                      rsv  rr     a0     a1    chk  d0         b0  d1         b1
      tbl[0]  = '{1'b1,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd5, 5'd5, 1'b0,64'h0,     1'b0,64'h0,     1'b0};
      tbl[1]  = '{1'b0,1'b1,5'd5, 64'h1234,              1'b0,5'd0, 5'd5, 5'd5, 1'b1,64'h1234,  1'b0,64'h1234,  1'b0};
      tbl[2]  = '{1'b0,1'b0,5'd0, 64'h0,                 1'b1,5'd5, 5'd5, 5'd5, 1'b1,64'h1234,  1'b0,64'h1234,  1'b0};
      tbl[3]  = '{1'b1,1'b1,5'd5, 64'h9999,              1'b0,5'd0, 5'd6, 5'd6, 1'b1,64'h0,     1'b0,64'h0,     1'b0};
      tbl[4]  = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd5, 5'd5, 1'b1,64'h0,     1'b0,64'h0,     1'b0};
      tbl[5]  = '{1'b0,1'b1,5'd3, DB,                    1'b0,5'd0, 5'd3, 5'd3, 1'b1,DB,        1'b0,DB,        1'b0};
      tbl[6]  = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd3, 5'd3, 1'b1,DB,        1'b0,DB,        1'b0};
      tbl[7]  = '{1'b0,1'b1,5'd31,64'hFFFF_FFFF_FFFF_FFFF,1'b1,5'd31,5'd31,5'd31,1'b1,64'h0,     1'b0,64'h0,     1'b0};
      tbl[8]  = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd31,5'd3, 1'b1,64'h0,     1'b0,DB,        1'b0};
      tbl[9]  = '{1'b0,1'b0,5'd0, 64'h0,                 1'b1,5'd7, 5'd7, 5'd7, 1'b1,64'h0,     1'b0,64'h0,     1'b0};
      tbl[10] = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd7, 5'd7, 1'b1,64'h0,     1'b1,64'h0,     1'b1};
      tbl[11] = '{1'b0,1'b1,5'd7, 64'h42,                1'b0,5'd0, 5'd7, 5'd7, 1'b1,64'h42,    1'b0,64'h42,    1'b0};
      tbl[12] = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd7, 5'd7, 1'b1,64'h42,    1'b0,64'h42,    1'b0};
      tbl[13] = '{1'b0,1'b1,5'd9, 64'h11,                1'b1,5'd9, 5'd9, 5'd9, 1'b1,64'h11,    1'b0,64'h11,    1'b0};
      tbl[14] = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd9, 5'd9, 1'b1,64'h11,    1'b1,64'h11,    1'b1};
      tbl[15] = '{1'b0,1'b1,5'd2, 64'h22,                1'b1,5'd4, 5'd2, 5'd4, 1'b1,64'h22,    1'b0,64'h0,     1'b0};
      tbl[16] = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd2, 5'd4, 1'b1,64'h22,    1'b0,64'h0,     1'b1};
      tbl[17] = '{1'b0,1'b1,5'd4, 64'h44,                1'b0,5'd0, 5'd4, 5'd9, 1'b1,64'h44,    1'b0,64'h11,    1'b1};
      tbl[18] = '{1'b0,1'b1,5'd5, 64'h55,                1'b1,5'd2, 5'd2, 5'd5, 1'b1,64'h22,    1'b0,64'h55,    1'b0};
      tbl[19] = '{1'b1,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd2, 5'd9, 1'b1,64'h22,    1'b1,64'h11,    1'b1};
      tbl[20] = '{1'b0,1'b0,5'd0, 64'h0,                 1'b0,5'd0, 5'd2, 5'd9, 1'b1,64'h0,     1'b0,64'h0,     1'b0};

      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin c_reg[i] = '0; c_busy[i] = 1'b0; end
      Reset = 1'b1;
      set_ab(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      set_c(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 12'h0);

      // Directed table.
      for (int i = 0; i < NV; i++) begin
         Reset = tbl[i].rst;
         set_ab(tbl[i].wr, tbl[i].rw, tbl[i].w, tbl[i].rsv, tbl[i].rr, tbl[i].a0, tbl[i].a1);
         @(negedge Clk);
         if (tbl[i].chk) begin
            check($sformatf("v%0d a_data0", i), if_a.BusA[63:0],   tbl[i].d0);
            check($sformatf("v%0d a_busy0", i), {63'd0, if_a.BusyA[0]}, {63'd0, tbl[i].b0});
            check($sformatf("v%0d a_data1", i), if_a.BusA[127:64], tbl[i].d1);
            check($sformatf("v%0d a_busy1", i), {63'd0, if_a.BusyA[1]}, {63'd0, tbl[i].b1});
            check_ab_model(1'b0);
         end
         tick();
      end

      // Without bypass, a write becomes visible only after the edge.
      set_ab(1'b1, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 5'd10, 5'd10);
      @(negedge Clk);
      check("nobyp r10 before edge", if_b.BusA[63:0], 64'h0);
      check("byp r10 same cycle", if_a.BusA[63:0], 64'h0123_4567_89AB_CDEF);
      tick();
      set_ab(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd10, 5'd10);
      @(negedge Clk);
      check("nobyp r10 after edge", if_b.BusA[127:64], 64'h0123_4567_89AB_CDEF);
      tick();

      // Without bypass, the busy clear by a write also waits for the edge.
      set_ab(1'b0, 5'd0, 64'h0, 1'b1, 5'd11, 5'd11, 5'd11);
      tick();
      set_ab(1'b1, 5'd11, 64'h77, 1'b0, 5'd0, 5'd11, 5'd11);
      @(negedge Clk);
      check("nobyp r11 busy in write cycle", {63'd0, if_b.BusyA[0]}, 64'd1);
      check("byp r11 busy in write cycle", {63'd0, if_a.BusyA[0]}, 64'd0);
      tick();
      set_ab(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd11, 5'd11);
      @(negedge Clk);
      check("nobyp r11 busy after write", {63'd0, if_b.BusyA[1]}, 64'd0);
      check("nobyp r11 data after write", if_b.BusA[127:64], 64'h77);
      tick();

      // Without a zero register, the top register of the small instance is writable.
      set_c(1'b1, 4'd15, 32'hCAFE_F00D, 1'b0, 4'd0, {4'd15, 4'd7, 4'd0});
      @(negedge Clk);
      check("c r15 bypass", {32'd0, if_c.BusA[95:64]}, {32'd0, 32'hCAFE_F00D});
      tick();
      set_c(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, {4'd15, 4'd7, 4'd0});
      @(negedge Clk);
      check("c r15 stored", {32'd0, if_c.BusA[95:64]}, {32'd0, 32'hCAFE_F00D});
      check("c r0", {32'd0, if_c.BusA[31:0]}, 64'd0);
      check("c r7", {32'd0, if_c.BusA[63:32]}, 64'd0);
      tick();

      // Random traffic on all instances, checked against the model.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rw, rr, a0;
         logic [3:0] crw, crr;
         logic [11:0] cra;
         Reset = ($urandom_range(0, 63) == 0);
         rw = pick_a();
         rr = pick_a();
         a0 = ($urandom_range(0, 1) == 1) ? rw : pick_a();
         set_ab(1'($urandom_range(0, 1)), rw, {$urandom, $urandom},
                1'($urandom_range(0, 2) == 0), rr, a0, pick_a());
         crw = 4'($urandom_range(0, 15));
         crr = ($urandom_range(0, 1) == 1) ? crw : 4'($urandom_range(0, 15));
         if (n % 2 == 0) cra = {4'd15, 4'd7, 4'd0};
         else            cra = {4'($urandom_range(0, 15)), crw, 4'($urandom_range(0, 15))};
         set_c(1'($urandom_range(0, 1)), crw, $urandom, 1'($urandom_range(0, 2) == 0), crr, cra);
         @(negedge Clk);
         check_ab_model(1'b1);
         check_c_model();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
